// File: rtl/adder_probe_initiator.sv
// ============================================================================
// Module  : adder_probe_initiator
// Purpose : Self-test initiator/checker for the registered 7-bit pin adder.
//           Generates pseudo-random operand pairs from a 16-bit LFSR, drives
//           them to the adder, waits a fixed latency, then compares the
//           returned 8-bit sum against the locally computed a+b.
//
// Parameters
//   LAT      cycles from operand update to a valid sum_in (>= 1)
//   NUM_VEC  vectors per run (1..255)
//   SEED     LFSR reset/restart value (must be nonzero)
//
// Ports
//   clk       in   1  clock, all state on rising edge
//   rst_n     in   1  asynchronous active-low reset
//   start     in   1  begin a run (sampled in IDLE or DONE only)
//   a_out     out  7  operand A to adder
//   b_out     out  7  operand B to adder
//   sum_in    in   8  sum returned by adder (bit 7 is the carry)
//   busy      out  1  run in progress (DRIVE/WAIT)
//   done      out  1  run finished, held until next start
//   pass      out  1  run finished with zero mismatches
//   err_cnt   out  8  mismatch count, saturates at 255
//   fail_idx  out  8  index of first failing vector (optional feature)
//   fail_sum  out  8  sum_in observed at first failure (optional feature)
//
// Configuration macro
//   PROBE_FIRST_FAIL_EN  when defined, captures the first failing vector
//                        index and observed sum; when undefined, fail_idx
//                        and fail_sum are tied to zero and no capture
//                        flops exist.
// ============================================================================
module adder_probe_initiator #(
    parameter int          LAT     = 1,
    parameter int          NUM_VEC = 16,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [6:0] a_out,
    output logic [6:0] b_out,
    input  logic [7:0] sum_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [7:0] fail_idx,
    output logic [7:0] fail_sum
);

    // Wait counter only has to hold LAT-1, but keep it at least one bit wide.
    localparam int         CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(LAT - 1);
    localparam logic [7:0] LAST_VEC = 8'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        WAIT,
        DONE
    } state_t;

    state_t        r_state;
    logic [15:0]   r_lfsr;
    logic [6:0]    r_aOut;
    logic [6:0]    r_bOut;
    logic [7:0]    r_vec;
    logic [CW-1:0] r_waitCnt;
    logic [7:0]    r_errCnt;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;

    logic          w_feedback;
    logic [15:0]   w_lfsrNext;
    logic [7:0]    w_expected;
    logic          w_mismatch;
    logic          w_startOk;
    logic          w_compare;
    logic [7:0]    w_errNext;

    // Next LFSR value: Fibonacci form of x^16+x^14+x^13+x^11+1, shifting
    // left with the feedback bit entering at bit 0.
    assign w_feedback = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_lfsrNext = {r_lfsr[14:0], w_feedback};

    // The reference sum is taken from the operands actually on the pins, so
    // the comparison always matches what the adder was given.
    assign w_expected = {1'b0, r_aOut} + {1'b0, r_bOut};
    assign w_mismatch = (sum_in != w_expected);

    // A run may only be launched from IDLE or DONE; start is ignored while
    // the probe is busy.
    assign w_startOk = start && ((r_state == IDLE) || (r_state == DONE));

    // The compare happens on the edge that ends the final WAIT cycle.
    assign w_compare = (r_state == WAIT) && (r_waitCnt == '0);

    // Error count including the current compare, clamped at 255 so that it
    // can never wrap back to zero and fake a pass.
    assign w_errNext = (w_compare && w_mismatch && (r_errCnt != 8'hFF))
                       ? r_errCnt + 8'd1 : r_errCnt;

    // Main sequencer. Each vector spends one DRIVE cycle plus LAT WAIT
    // cycles, giving a vector period of LAT+1 clocks. Operands for the next
    // vector are loaded on the same edge as the compare, so the adder sees
    // the new pair while the FSM sits in DRIVE. busy/done/pass are
    // registered alongside the state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_lfsr    <= SEED;
            r_aOut    <= '0;
            r_bOut    <= '0;
            r_vec     <= '0;
            r_waitCnt <= '0;
            r_errCnt  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_startOk) begin
                        r_state  <= DRIVE;
                        r_lfsr   <= SEED;
                        r_aOut   <= SEED[6:0];
                        r_bOut   <= SEED[14:8];
                        r_vec    <= '0;
                        r_errCnt <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                    end
                end
                DRIVE: begin
                    r_state   <= WAIT;
                    r_waitCnt <= WAIT_INIT;
                end
                WAIT: begin
                    if (r_waitCnt != '0) begin
                        r_waitCnt <= r_waitCnt - 1'b1;
                    end else begin
                        r_errCnt <= w_errNext;
                        if (r_vec == LAST_VEC) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_errNext == 8'd0);
                        end else begin
                            r_state <= DRIVE;
                            r_vec   <= r_vec + 8'd1;
                            r_lfsr  <= w_lfsrNext;
                            r_aOut  <= w_lfsrNext[6:0];
                            r_bOut  <= w_lfsrNext[14:8];
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PROBE_FIRST_FAIL_EN
    logic [7:0] r_failIdx;
    logic [7:0] r_failSum;
    logic       r_failSeen;

    // First-failure capture. Only the earliest mismatch of a run is kept;
    // the record is wiped whenever a new run is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_failIdx  <= '0;
            r_failSum  <= '0;
            r_failSeen <= 1'b0;
        end else if (w_startOk) begin
            r_failIdx  <= '0;
            r_failSum  <= '0;
            r_failSeen <= 1'b0;
        end else if (w_compare && w_mismatch && !r_failSeen) begin
            r_failIdx  <= r_vec;
            r_failSum  <= sum_in;
            r_failSeen <= 1'b1;
        end
    end

    assign fail_idx = r_failIdx;
    assign fail_sum = r_failSum;
`else
    assign fail_idx = 8'd0;
    assign fail_sum = 8'd0;
`endif

    assign a_out   = r_aOut;
    assign b_out   = r_bOut;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign err_cnt = r_errCnt;

endmodule
